// File: rtl/bus_addr_sender_pkg.sv
// Shared types and constants for the address sender and its echo timer.
// Latency: n/a (types, constants and a pure frame-building function).
// Backpressure: n/a.
package bus_addr_sender_pkg;

    // Controller states; any code outside this set falls back to IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_ECHO = 3'd3,
        DONE      = 3'd4,
        ERR       = 3'd5
    } state_t;

    // Top two bits of every transmitted byte mark it as an address frame.
    localparam logic [1:0] OPCODE_PREFIX = 2'b10;

    // Four nibbles per 16-bit address, so the nibble index is two bits.
    localparam int IDX_W = 2;
    localparam logic [IDX_W-1:0] IDX_LAST = 2'd3;

    // Frame layout: {prefix, nibble index, nibble value}.
    function automatic logic [7:0] make_frame(input logic [IDX_W-1:0] idx,
                                              input logic [15:0]      addr);
        return {OPCODE_PREFIX, idx, addr[{idx, 2'b00} +: 4]};
    endfunction

endpackage

// File: rtl/bus_addr_sender_echo_timer.sv
// Echo timer: counts WAIT_ECHO cycles and flags when the echo window has run out.
// Latency: expired asserts on the TIMEOUT_CYCLES-th enabled cycle after clear.
// Backpressure: none; the count saturates at its terminal value and never wraps.
// Ports: clk/rst_n (sync, active-low), clear (zero the count), enable (count this cycle),
//        expired (count has reached TIMEOUT_CYCLES-1).
module echo_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import bus_addr_sender_pkg::*;

    // A one-cycle timeout still needs a 1-bit counter to be legal.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/bus_addr_sender.sv
// Sends a 16-bit address as four nibble frames over a UART, checking each echo.
// Latency: start to first tx_en is 3 cycles when the transmitter is free.
// Backpressure: waits in SEND while tx_busy; resends on bad/missing echo, err after RETRY_MAX.
// Ports: clk/rst_n (sync, active-low); start/addr_in request; busy/done/err status;
//        tx_data/tx_en/tx_busy to the transmitter; rx_data/rx_en from the receiver.
module bus_addr_sender
    import bus_addr_sender_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int RETRY_MAX      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] addr_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_en
);

    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [RW-1:0]    retry, retry_nxt;
    logic [15:0]      addr, addr_nxt;
    logic [7:0]       tx_data_nxt;
    logic             tx_en_nxt;
    logic             timer_clear, timer_en, timer_expired;
    logic             attempt_fail;

    echo_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_echo_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        retry_nxt    = retry;
        addr_nxt     = addr;
        tx_data_nxt  = tx_data;
        tx_en_nxt    = 1'b0;
        timer_clear  = 1'b0;
        timer_en     = 1'b0;
        attempt_fail = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = addr_in;
                    idx_nxt   = '0;
                    retry_nxt = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                tx_data_nxt = make_frame(idx, addr);
                timer_clear = 1'b1;
                state_nxt   = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_en_nxt = 1'b1;
                    state_nxt = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                timer_en = 1'b1;
                // An echo arriving on the expiry cycle wins over the timeout.
                if (rx_en) begin
                    if (rx_data == tx_data) begin
                        if (idx == IDX_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt   = idx + 1'b1;
                            retry_nxt = '0;
                            state_nxt = LOAD;
                        end
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (timer_expired) begin
                    attempt_fail = 1'b1;
                end

                if (attempt_fail) begin
                    if (retry < RETRY_LIM) begin
                        retry_nxt = retry + RW'(1);
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            retry   <= '0;
            addr    <= '0;
            tx_data <= '0;
            tx_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            retry   <= retry_nxt;
            addr    <= addr_nxt;
            tx_data <= tx_data_nxt;
            tx_en   <= tx_en_nxt;
            busy    <= (state_nxt == LOAD) || (state_nxt == SEND) || (state_nxt == WAIT_ECHO);
            done    <= (state_nxt == DONE);
            err     <= (state_nxt == ERR);
        end
    end

endmodule

// File: tb/tb_bus_addr_sender.sv
// Bench for bus_addr_sender: loopback responder, cycle-level reference model, directed and random runs.
module tb_bus_addr_sender;

    localparam int TO = 16;
    localparam int RM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] addr_in = 16'h0;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_en = 1'b0;
    logic        busy, done, err, tx_en;
    logic [7:0]  tx_data;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    bus_addr_sender #(
        .TIMEOUT_CYCLES(TO),
        .RETRY_MAX     (RM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .addr_in(addr_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .tx_data(tx_data),
        .tx_en  (tx_en),
        .tx_busy(tx_busy),
        .rx_data(rx_data),
        .rx_en  (rx_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected frame from the address rule: 0x80 + 16*index + selected nibble.
    function automatic logic [7:0] frame_of(input logic [15:0] a, input int i);
        int v;
        v = 128 + i * 16 + ((int'(a) >> (4 * i)) & 15);
        return 8'(v);
    endfunction

    // ---------------- loopback responder ----------------
    int         echo_lo = 1, echo_hi = 1, corrupt_send = -1, send_no = 0;
    bit         no_echo = 1'b0, noise = 1'b0;
    logic [7:0] txlog[$];
    int         txcyc[$];
    bit         r_pend = 1'b0;
    int         r_when = 0;
    logic [7:0] r_val = 8'h0;

    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) r_pend = 1'b0;
            if (tx_en) begin
                txlog.push_back(tx_data);
                txcyc.push_back(cyc);
                if (!no_echo) begin
                    r_pend = 1'b1;
                    r_when = cyc + int'($urandom_range(echo_hi, echo_lo));
                    r_val  = (send_no == corrupt_send) ? 8'h00 : tx_data;
                end
                send_no++;
            end
            rx_en   = 1'b0;
            rx_data = 8'($urandom);
            if (r_pend && cyc == r_when) begin
                rx_en   = 1'b1;
                rx_data = r_val;
                r_pend  = 1'b0;
            end else if (noise && $urandom_range(15, 0) == 0) begin
                rx_en = 1'b1;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // The model tracks the transfer as deadlines: when the frame loads, the
    // earliest send cycle, the echo window start, and when start is accepted.
    bit         known = 1'b0;
    bit         m_active = 1'b0, m_pend = 1'b0, m_wait = 1'b0;
    int         k = 0, m_idx = 0, m_retry = 0, m_load = -1, m_send_from = 0, m_wait_from = 0, idle_from = 0;
    logic [15:0] m_addr = 16'h0;
    logic       e_txen = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [7:0] e_data = 8'h0;
    int         done_seen = 0, err_seen = 0;

    task automatic next_attempt(input int now);
        m_load      = now + 1;
        m_pend      = 1'b1;
        m_send_from = now + 2;
    endtask

    initial begin : compare
        logic       n_txen, n_done, n_err, ok, fail;
        logic [7:0] n_data;
        forever begin
            @(negedge clk);
            if (known) begin
                check("tx_en",   32'(tx_en),   32'(e_txen));
                check("busy",    32'(busy),    32'(e_busy));
                check("done",    32'(done),    32'(e_done));
                check("err",     32'(err),     32'(e_err));
                check("tx_data", 32'(tx_data), 32'(e_data));
                if (done === 1'b1) done_seen++;
                if (err === 1'b1) err_seen++;
            end
            n_txen = 1'b0;
            n_done = 1'b0;
            n_err  = 1'b0;
            n_data = e_data;
            if (!rst_n) begin
                known     = 1'b1;
                m_active  = 1'b0;
                m_pend    = 1'b0;
                m_wait    = 1'b0;
                m_load    = -1;
                n_data    = 8'h00;
                idle_from = k + 1;
            end else if (known) begin
                if (m_load == k) n_data = frame_of(m_addr, m_idx);
                if (!m_active) begin
                    if (start && k >= idle_from) begin
                        m_active = 1'b1;
                        m_addr   = addr_in;
                        m_idx    = 0;
                        m_retry  = 0;
                        next_attempt(k);
                    end
                end else if (m_pend) begin
                    if (k >= m_send_from && !tx_busy) begin
                        n_txen      = 1'b1;
                        m_pend      = 1'b0;
                        m_wait      = 1'b1;
                        m_wait_from = k + 1;
                    end
                end else if (m_wait) begin
                    ok   = 1'b0;
                    fail = 1'b0;
                    if (rx_en) begin
                        if (rx_data == frame_of(m_addr, m_idx)) ok = 1'b1;
                        else fail = 1'b1;
                    end else if (k == m_wait_from + TO - 1) begin
                        fail = 1'b1;
                    end
                    if (ok) begin
                        m_wait = 1'b0;
                        if (m_idx == 3) begin
                            n_done    = 1'b1;
                            m_active  = 1'b0;
                            idle_from = k + 2;
                        end else begin
                            m_idx++;
                            m_retry = 0;
                            next_attempt(k);
                        end
                    end
                    if (fail) begin
                        m_wait = 1'b0;
                        if (m_retry < RM) begin
                            m_retry++;
                            next_attempt(k);
                        end else begin
                            n_err     = 1'b1;
                            m_active  = 1'b0;
                            idle_from = k + 2;
                        end
                    end
                end
            end
            e_txen = n_txen;
            e_done = n_done;
            e_err  = n_err;
            e_data = n_data;
            e_busy = m_active;
            k++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [15:0] a);
        addr_in = a;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        bit to;
        to = 1'b1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done || err) begin
                to = 1'b0;
                break;
            end
        end
        if (to) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_end: no done/err within %0d cycles", bound);
        end
        tick(2);
    endtask

    task automatic clear_log();
        txlog.delete();
        txcyc.delete();
        send_no   = 0;
        done_seen = 0;
        err_seen  = 0;
    endtask

    task automatic check_log(input string name, input int n, input logic [63:0] bytes);
        check({name, "_count"}, txlog.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < txlog.size()) check(name, 32'(txlog[i]), 32'(bytes[8 * (n - 1 - i) +: 8]));
        end
    endtask

    initial begin : main
        int s_cyc, fall;

        // Reset state.
        rst_n = 1'b0;
        tick(3);
        check("rst_busy",    32'(busy),    0);
        check("rst_tx_en",   32'(tx_en),   0);
        check("rst_done",    32'(done),    0);
        check("rst_err",     32'(err),     0);
        check("rst_tx_data", 32'(tx_data), 0);
        rst_n = 1'b1;
        tick();

        // BEEF with ideal loopback; first strobe 3 cycles after start.
        clear_log();
        s_cyc = cyc;
        pulse_start(16'hBEEF);
        wait_end(200);
        check_log("beef", 4, 64'h8F9EAEBB);
        check("beef_done", done_seen, 1);
        check("beef_err", err_seen, 0);
        if (txcyc.size() > 0) check("first_latency", txcyc[0] - s_cyc, 3);

        // Transmitter busy for 10 cycles from start.
        clear_log();
        tx_busy = 1'b1;
        s_cyc = cyc;
        pulse_start(16'hBEEF);
        tick(9);
        tx_busy = 1'b0;
        fall = cyc;
        wait_end(200);
        check("txbusy_cycles", fall - s_cyc, 10);
        if (txcyc.size() > 0) check("txbusy_first_en", txcyc[0] - fall, 1);
        check_log("txbusy", 4, 64'h8F9EAEBB);
        check("txbusy_done", done_seen, 1);

        // Byte 1 echoed as 0x00 once -> resend.
        clear_log();
        corrupt_send = 1;
        pulse_start(16'hBEEF);
        wait_end(300);
        corrupt_send = -1;
        check_log("corrupt", 5, 64'h8F9E9EAEBB);
        check("corrupt_done", done_seen, 1);
        check("corrupt_err", err_seen, 0);

        // No echo at all -> 4 sends, one err.
        clear_log();
        no_echo = 1'b1;
        pulse_start(16'hBEEF);
        wait_end(400);
        no_echo = 1'b0;
        check_log("noecho", 4, 64'h8F8F8F8F);
        check("noecho_err", err_seen, 1);
        check("noecho_done", done_seen, 0);
        check("noecho_busy", 32'(busy), 0);

        // Reset during WAIT_ECHO of byte 2, then fresh start of 0x1234.
        clear_log();
        echo_lo = 6;
        echo_hi = 6;
        pulse_start(16'hBEEF);
        for (int i = 0; i < 200 && txlog.size() < 3; i++) tick();
        check("midrst_reached", txlog.size(), 3);
        tick(2);
        rst_n = 1'b0;
        tick();
        check("midrst_busy",    32'(busy),    0);
        check("midrst_tx_en",   32'(tx_en),   0);
        check("midrst_done",    32'(done),    0);
        check("midrst_err",     32'(err),     0);
        check("midrst_tx_data", 32'(tx_data), 0);
        tick();
        echo_lo = 1;
        echo_hi = 1;
        txlog.delete();
        rst_n = 1'b1;
        pulse_start(16'h1234);
        wait_end(200);
        check_log("after_rst", 4, 64'h8493A2B1);
        check("after_rst_done", done_seen, 1);
        check("after_rst_err", err_seen, 0);

        // Repeated start pulses while busy are ignored.
        clear_log();
        echo_lo = 2;
        echo_hi = 2;
        pulse_start(16'hBEEF);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
                start   = (i % 3 == 0);
                addr_in = 16'h1234;
                tick();
                if (done || err) begin
                    seen = 1'b1;
                    break;
                end
            end
            start = 1'b0;
            check("restart_finished", 32'(seen), 1);
        end
        tick(2);
        check_log("restart", 4, 64'h8F9EAEBB);
        check("restart_done", done_seen, 1);

        // Randomized traffic checked by the model.
        for (int blk = 0; blk < 30; blk++) begin
            send_no = 0;
            echo_lo = int'($urandom_range(2, 0));
            echo_hi = echo_lo + int'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) corrupt_send = int'($urandom_range(8, 0));
            else corrupt_send = -1;
            noise   = ($urandom_range(3, 0) == 0);
            no_echo = ($urandom_range(9, 0) == 0);
            for (int c = 0; c < 100; c++) begin
                tx_busy = ($urandom_range(2, 0) == 0);
                start   = ($urandom_range(5, 0) == 0);
                addr_in = 16'($urandom);
                rst_n   = ($urandom_range(299, 0) != 0);
                tick();
            end
        end
        start   = 1'b0;
        tx_busy = 1'b0;
        rst_n   = 1'b1;
        no_echo = 1'b0;
        noise   = 1'b0;
        tick(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
